// File: rtl/dcim_bitserial_mac_array_if.sv
// Host-side bus of the bit-serial DCIM MAC array: weight writes, run control and results.
interface dcim_bitserial_mac_array_if #(
  parameter int N_IN    = 16,
  parameter int NCOL    = 4,
  parameter int W_BITS  = 8,
  parameter int IN_BITS = 8
);
  localparam int ACC_W = W_BITS + IN_BITS + $clog2(N_IN);

  logic                         we;
  logic [$clog2(N_IN)-1:0]      wa;
  logic [NCOL*W_BITS-1:0]       d_in;
  logic                         start;
  logic [$clog2(IN_BITS+1)-1:0] in_prec;
  logic                         x_signed;
  logic [N_IN*IN_BITS-1:0]      xin;
  logic                         busy;
  logic                         done;
  logic [NCOL*ACC_W-1:0]        nout;

  modport master (
    output we, wa, d_in, start, in_prec, x_signed, xin,
    input  busy, done, nout
  );

  modport slave (
    input  we, wa, d_in, start, in_prec, x_signed, xin,
    output busy, done, nout
  );
endinterface

// File: rtl/dcim_bitserial_mac_array.sv
// Bit-serial DCIM MAC macro: NCOL signed dot products of an N_IN-lane input vector
// against a stored weight array, one input bit plane per cycle, MSB first.
module dcim_bitserial_mac_array #(
  parameter int N_IN    = 16,
  parameter int NCOL    = 4,
  parameter int W_BITS  = 8,
  parameter int IN_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  dcim_bitserial_mac_array_if.slave  bus
);
  localparam int ACC_W = W_BITS + IN_BITS + $clog2(N_IN);
  localparam int PW    = $clog2(IN_BITS + 1);
  localparam int BW    = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_nx;
  logic                      busy_c;
  logic signed [W_BITS-1:0]  w_mem [N_IN][NCOL];
  logic [IN_BITS-1:0]        x_lane [N_IN];
  logic [BW-1:0]             bit_idx;
  logic [BW-1:0]             top_idx;
  logic                      x_sgn;
  logic signed [ACC_W-1:0]   acc [NCOL];
  logic signed [ACC_W-1:0]   pp [NCOL];
  logic [PW-1:0]             p_eff;
  logic [PW-1:0]             p_m1;
  logic [BW-1:0]             msb_idx;
  logic                      done_q;
  logic [NCOL*ACC_W-1:0]     nout_q;

  // Out-of-range precision codes fall back to the full lane width.
  always_comb begin
    p_eff = bus.in_prec;
    if (bus.in_prec == '0 || bus.in_prec > PW'(IN_BITS)) begin
      p_eff = PW'(IN_BITS);
    end
    p_m1    = p_eff - 1'b1;
    msb_idx = p_m1[BW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (bit_idx == '0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        busy_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Partial product of the current bit plane for every column.
  always_comb begin
    for (int c = 0; c < NCOL; c++) begin
      pp[c] = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (x_lane[i][bit_idx]) begin
          pp[c] = pp[c] + ACC_W'(w_mem[i][c]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) begin
        x_lane[i] <= '0;
        for (int c = 0; c < NCOL; c++) begin
          w_mem[i][c] <= '0;
        end
      end
      for (int c = 0; c < NCOL; c++) begin
        acc[c] <= '0;
      end
      bit_idx <= '0;
      top_idx <= '0;
      x_sgn   <= 1'b0;
      done_q  <= 1'b0;
      nout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.we) begin
            for (int c = 0; c < NCOL; c++) begin
              w_mem[bus.wa][c] <= $signed(bus.d_in[c*W_BITS +: W_BITS]);
            end
          end
          if (bus.start) begin
            for (int i = 0; i < N_IN; i++) begin
              x_lane[i] <= bus.xin[i*IN_BITS +: IN_BITS];
            end
            for (int c = 0; c < NCOL; c++) begin
              acc[c] <= '0;
            end
            bit_idx <= msb_idx;
            top_idx <= msb_idx;
            x_sgn   <= bus.x_signed;
          end
        end
        // The sign plane of a two's-complement input carries negative weight.
        RUN: begin
          for (int c = 0; c < NCOL; c++) begin
            if (x_sgn && bit_idx == top_idx) begin
              acc[c] <= (acc[c] <<< 1) - pp[c];
            end else begin
              acc[c] <= (acc[c] <<< 1) + pp[c];
            end
          end
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - 1'b1;
          end
        end
        DONE: begin
          for (int c = 0; c < NCOL; c++) begin
            nout_q[c*ACC_W +: ACC_W] <= acc[c];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.nout = nout_q;
endmodule
